// File: rtl/register_file_mp_pkg.sv
// Shared types for the multi-ported register file.
//   XLEN    : data word width
//   NREGS   : architectural register count (x0 hardwired to zero)
//   word_st : one data word
//   reg_e   : register index
package register_file_mp_pkg;
    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int REG_W = $clog2(NREGS);

    typedef logic [XLEN-1:0]  word_st;
    typedef logic [REG_W-1:0] reg_e;
endpackage

// File: rtl/register_file_mp_if.sv
// Register file bus: read ports, writeback ports and the issue handshake.
//   rs_a_i/rs_d_o/rs_busy_o    : NUM_RD read address, data, pending flag
//   wb_we_i/wb_a_i/wb_d_i      : NUM_WR writeback enable, address, data
//   iss_valid_i/iss_a_i        : issue request and destination register
//   iss_ready_o                : destination has no write outstanding
// master = requester side, slave = register file side.
interface register_file_mp_if
    import register_file_mp_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2
);
    reg_e   [NUM_RD-1:0] rs_a_i;
    word_st [NUM_RD-1:0] rs_d_o;
    logic   [NUM_RD-1:0] rs_busy_o;
    logic   [NUM_WR-1:0] wb_we_i;
    reg_e   [NUM_WR-1:0] wb_a_i;
    word_st [NUM_WR-1:0] wb_d_i;
    logic                iss_valid_i;
    reg_e                iss_a_i;
    logic                iss_ready_o;

    modport master (
        output rs_a_i, wb_we_i, wb_a_i, wb_d_i, iss_valid_i, iss_a_i,
        input  rs_d_o, rs_busy_o, iss_ready_o
    );

    modport slave (
        input  rs_a_i, wb_we_i, wb_a_i, wb_d_i, iss_valid_i, iss_a_i,
        output rs_d_o, rs_busy_o, iss_ready_o
    );
endinterface

// File: rtl/register_file_mp_scoreboard.sv
// Pending-write scoreboard: one bit per register, set by an accepted issue,
// cleared by a writeback. Also provides the issue-ready and per-read-port
// pending lookups.
//   clk_i, rst_i : clock, synchronous active-high reset
//   iss_valid    : issue request
//   iss_a        : issue destination
//   iss_ready    : destination not pending (always 1 for x0)
//   clr          : one-hot-per-register writeback clear mask
//   rd_a         : read port addresses
//   rd_pend      : pending bit of each read address
module register_file_mp_scoreboard
    import register_file_mp_pkg::*;
#(
    parameter int NUM_RD = 2
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              iss_valid,
    input  reg_e              iss_a,
    output logic              iss_ready,
    input  logic [NREGS-1:0]  clr,
    input  reg_e [NUM_RD-1:0] rd_a,
    output logic [NUM_RD-1:0] rd_pend
);
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pending_nxt;
    logic             accept;

    assign iss_ready = (iss_a == '0) || !pending[iss_a];
    assign accept    = iss_valid && iss_ready;

    // Clear first, then set: an issue and a writeback to the same register
    // in one cycle leave it pending (the new producer still owes a write).
    always_comb begin
        pending_nxt = pending & ~clr;
        if (accept) pending_nxt[iss_a] = 1'b1;
        pending_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) pending <= '0;
        else       pending <= pending_nxt;
    end

    always_comb begin
        rd_pend = '0;
        for (int i = 0; i < NUM_RD; i++) rd_pend[i] = pending[rd_a[i]];
    end
endmodule

// File: rtl/register_file_mp.sv
// Multi-ported register file with write-after-write scoreboard and optional
// same-cycle writeback forwarding.
//   NUM_RD  : read ports (1..4)
//   NUM_WR  : writeback ports (1..2); higher index wins on address collision
//   BYPASS  : 1 = enabled writeback data is forwarded to matching reads
//   clk_i   : clock
//   rst_i   : synchronous active-high reset
//   bus     : register_file_mp_if slave (reads, writebacks, issue)
module register_file_mp
    import register_file_mp_pkg::*;
#(
    parameter int NUM_RD = 2,
    parameter int NUM_WR = 2,
    parameter int BYPASS = 1
) (
    input  logic              clk_i,
    input  logic              rst_i,
    register_file_mp_if.slave bus
);
    word_st           regs [NREGS];
    logic [NREGS-1:0] wb_clr;
    logic [NUM_RD-1:0] rd_pend;
    logic             iss_ready_sb;

    // Ascending loop: a later port's assignment overrides an earlier one,
    // giving the highest-indexed port priority on a shared address.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int r = 0; r < NREGS; r++) regs[r] <= '0;
        end else begin
            for (int j = 0; j < NUM_WR; j++)
                if (bus.wb_we_i[j] && bus.wb_a_i[j] != '0)
                    regs[bus.wb_a_i[j]] <= bus.wb_d_i[j];
        end
    end

    always_comb begin
        wb_clr = '0;
        for (int j = 0; j < NUM_WR; j++)
            if (bus.wb_we_i[j] && bus.wb_a_i[j] != '0) wb_clr[bus.wb_a_i[j]] = 1'b1;
    end

    register_file_mp_scoreboard #(.NUM_RD(NUM_RD)) u_sb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .iss_valid (bus.iss_valid_i),
        .iss_a     (bus.iss_a_i),
        .iss_ready (iss_ready_sb),
        .clr       (wb_clr),
        .rd_a      (bus.rs_a_i),
        .rd_pend   (rd_pend)
    );

    // While reset is asserted the pending vector is about to be wiped, so
    // report the post-reset view: nothing busy, issue always ready.
    assign bus.iss_ready_o = iss_ready_sb | rst_i;

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        word_st rd_d;
        logic   rd_busy;

        always_comb begin
            rd_d    = (bus.rs_a_i[i] == '0) ? '0 : regs[bus.rs_a_i[i]];
            rd_busy = rd_pend[i] & ~rst_i;
            // Writes are dropped under reset, so nothing is forwarded then.
            if (BYPASS != 0 && !rst_i && bus.rs_a_i[i] != '0) begin
                for (int j = 0; j < NUM_WR; j++) begin
                    if (bus.wb_we_i[j] && bus.wb_a_i[j] == bus.rs_a_i[i]) begin
                        rd_d    = bus.wb_d_i[j];
                        rd_busy = 1'b0;
                    end
                end
            end
        end

        assign bus.rs_d_o[i]    = rd_d;
        assign bus.rs_busy_o[i] = rd_busy;
    end
endmodule

// File: tb/tb_register_file_mp.sv
// Directed bench: one DUT with forwarding, one without, driven identically.
module tb_register_file_mp;
    import register_file_mp_pkg::*;

    logic clk_i = 1'b0;
    logic rst_i;
    int   checks = 0;
    int   errors = 0;

    always #5 clk_i = ~clk_i;

    register_file_mp_if #(.NUM_RD(2), .NUM_WR(2)) bus ();
    register_file_mp_if #(.NUM_RD(2), .NUM_WR(2)) bus_nb ();

    assign bus_nb.rs_a_i      = bus.rs_a_i;
    assign bus_nb.wb_we_i     = bus.wb_we_i;
    assign bus_nb.wb_a_i      = bus.wb_a_i;
    assign bus_nb.wb_d_i      = bus.wb_d_i;
    assign bus_nb.iss_valid_i = bus.iss_valid_i;
    assign bus_nb.iss_a_i     = bus.iss_a_i;

    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(1)) dut (
        .clk_i (clk_i), .rst_i (rst_i), .bus (bus)
    );
    register_file_mp #(.NUM_RD(2), .NUM_WR(2), .BYPASS(0)) dut_nb (
        .clk_i (clk_i), .rst_i (rst_i), .bus (bus_nb)
    );

    // Inputs change on the falling edge; checks happen 1 time unit later.
    task automatic step();
        @(posedge clk_i);
        @(negedge clk_i);
    endtask

    task automatic idle();
        bus.wb_we_i     = '0;
        bus.wb_a_i      = '0;
        bus.wb_d_i      = '0;
        bus.iss_valid_i = 1'b0;
        bus.iss_a_i     = '0;
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        idle();
        bus.rs_a_i = '0;
        step();
        step();
        rst_i = 1'b0;
        for (int r = 1; r < NREGS; r++) begin
            bus.rs_a_i[0] = reg_e'(r);
            bus.rs_a_i[1] = reg_e'(r);
            bus.iss_a_i   = reg_e'(r);
            #1;
            for (int p = 0; p < 2; p++) begin
                checks++;
                if (bus.rs_d_o[p] !== '0 || bus.rs_busy_o[p] !== 1'b0 ||
                    bus_nb.rs_d_o[p] !== '0 || bus_nb.rs_busy_o[p] !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_read r=%0d p=%0d got d=%h/%h busy=%b/%b want 0/0 0/0",
                             r, p, bus.rs_d_o[p], bus_nb.rs_d_o[p], bus.rs_busy_o[p], bus_nb.rs_busy_o[p]);
                end
            end
            checks++;
            if (bus.iss_ready_o !== 1'b1) begin
                errors++;
                $display("FAIL reset_ready r=%0d got %b want 1", r, bus.iss_ready_o);
            end
            @(negedge clk_i);
        end
        idle();
    endtask

    task automatic test_bypass();
        bus.wb_we_i[0] = 1'b1;
        bus.wb_a_i[0]  = 5'd5;
        bus.wb_d_i[0]  = 32'hDEADBEEF;
        bus.rs_a_i[0]  = 5'd5;
        #1;
        checks++;
        if (bus.rs_d_o[0] !== 32'hDEADBEEF) begin
            errors++; $display("FAIL bypass_fwd got %h want deadbeef", bus.rs_d_o[0]);
        end
        checks++;
        if (bus_nb.rs_d_o[0] !== 32'h0) begin
            errors++; $display("FAIL nobypass_old got %h want 0", bus_nb.rs_d_o[0]);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rs_d_o[0] !== 32'hDEADBEEF || bus_nb.rs_d_o[0] !== 32'hDEADBEEF) begin
            errors++;
            $display("FAIL bypass_after got %h/%h want deadbeef", bus.rs_d_o[0], bus_nb.rs_d_o[0]);
        end
        checks++;
        if (bus.rs_busy_o[0] !== 1'b0 || bus_nb.rs_busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL wb_nonpending_busy got %b/%b want 0", bus.rs_busy_o[0], bus_nb.rs_busy_o[0]);
        end
    endtask

    task automatic test_wr_priority();
        bus.wb_we_i   = 2'b11;
        bus.wb_a_i[0] = 5'd7; bus.wb_d_i[0] = 32'h11;
        bus.wb_a_i[1] = 5'd7; bus.wb_d_i[1] = 32'h22;
        bus.rs_a_i[1] = 5'd7;
        #1;
        checks++;
        if (bus.rs_d_o[1] !== 32'h22) begin
            errors++; $display("FAIL prio_fwd got %h want 22", bus.rs_d_o[1]);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rs_d_o[1] !== 32'h22 || bus_nb.rs_d_o[1] !== 32'h22) begin
            errors++; $display("FAIL prio_store got %h/%h want 22", bus.rs_d_o[1], bus_nb.rs_d_o[1]);
        end
    endtask

    task automatic test_issue();
        bus.iss_valid_i = 1'b1;
        bus.iss_a_i     = 5'd3;
        bus.rs_a_i[0]   = 5'd3;
        #1;
        checks++;
        if (bus.iss_ready_o !== 1'b1 || bus.rs_busy_o[0] !== 1'b0) begin
            errors++;
            $display("FAIL issue_pre got ready=%b busy=%b want 1 0", bus.iss_ready_o, bus.rs_busy_o[0]);
        end
        step();
        #1;
        checks++;
        if (bus.rs_busy_o[0] !== 1'b1 || bus.iss_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL issue_set got busy=%b ready=%b want 1 0", bus.rs_busy_o[0], bus.iss_ready_o);
        end
        // Request held while stalled: still pending, still not ready.
        step();
        #1;
        checks++;
        if (bus.rs_busy_o[0] !== 1'b1 || bus.iss_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL issue_stall got busy=%b ready=%b want 1 0", bus.rs_busy_o[0], bus.iss_ready_o);
        end
        idle();
        bus.wb_we_i[0] = 1'b1;
        bus.wb_a_i[0]  = 5'd3;
        bus.wb_d_i[0]  = 32'h5;
        #1;
        checks++;
        if (bus.rs_busy_o[0] !== 1'b0 || bus_nb.rs_busy_o[0] !== 1'b1 || bus_nb.rs_d_o[0] !== 32'h0) begin
            errors++;
            $display("FAIL wb_same_cycle got busy=%b nb_busy=%b nb_d=%h want 0 1 0",
                     bus.rs_busy_o[0], bus_nb.rs_busy_o[0], bus_nb.rs_d_o[0]);
        end
        step();
        idle();
        bus.iss_a_i = 5'd3;
        #1;
        checks++;
        if (bus.rs_busy_o[0] !== 1'b0 || bus_nb.rs_busy_o[0] !== 1'b0 ||
            bus.rs_d_o[0] !== 32'h5 || bus_nb.rs_d_o[0] !== 32'h5 || bus.iss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL wb_clear got busy=%b/%b d=%h/%h ready=%b want 0/0 5/5 1",
                     bus.rs_busy_o[0], bus_nb.rs_busy_o[0], bus.rs_d_o[0], bus_nb.rs_d_o[0], bus.iss_ready_o);
        end
        idle();
    endtask

    task automatic test_issue_wb_same();
        bus.iss_valid_i = 1'b1;
        bus.iss_a_i     = 5'd4;
        bus.wb_we_i[1]  = 1'b1;
        bus.wb_a_i[1]   = 5'd4;
        bus.wb_d_i[1]   = 32'h9;
        bus.rs_a_i[0]   = 5'd4;
        step();
        idle();
        #1;
        checks++;
        if (bus.rs_d_o[0] !== 32'h9 || bus_nb.rs_d_o[0] !== 32'h9 ||
            bus.rs_busy_o[0] !== 1'b1 || bus_nb.rs_busy_o[0] !== 1'b1) begin
            errors++;
            $display("FAIL iss_wb_same got d=%h/%h busy=%b/%b want 9/9 1/1",
                     bus.rs_d_o[0], bus_nb.rs_d_o[0], bus.rs_busy_o[0], bus_nb.rs_busy_o[0]);
        end
    endtask

    task automatic test_x0();
        bus.wb_we_i[0]  = 1'b1;
        bus.wb_a_i[0]   = 5'd0;
        bus.wb_d_i[0]   = 32'hFFFF;
        bus.iss_valid_i = 1'b1;
        bus.iss_a_i     = 5'd0;
        bus.rs_a_i[1]   = 5'd0;
        #1;
        checks++;
        if (bus.rs_d_o[1] !== 32'h0 || bus.rs_busy_o[1] !== 1'b0 || bus.iss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_same got d=%h busy=%b ready=%b want 0 0 1",
                     bus.rs_d_o[1], bus.rs_busy_o[1], bus.iss_ready_o);
        end
        step();
        idle();
        #1;
        checks++;
        if (bus.rs_d_o[1] !== 32'h0 || bus_nb.rs_d_o[1] !== 32'h0 ||
            bus.rs_busy_o[1] !== 1'b0 || bus.iss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL x0_after got d=%h/%h busy=%b ready=%b want 0/0 0 1",
                     bus.rs_d_o[1], bus_nb.rs_d_o[1], bus.rs_busy_o[1], bus.iss_ready_o);
        end
    endtask

    task automatic test_reset_mid();
        bus.wb_we_i[0] = 1'b1;
        bus.wb_a_i[0]  = 5'd8;
        bus.wb_d_i[0]  = 32'h77;
        step();
        idle();
        bus.iss_valid_i = 1'b1;
        bus.iss_a_i     = 5'd8;
        step();
        idle();
        bus.rs_a_i[0] = 5'd8;
        bus.rs_a_i[1] = 5'd4;
        bus.iss_a_i   = 5'd8;
        #1;
        checks++;
        if (bus.rs_busy_o[0] !== 1'b1 || bus.rs_d_o[0] !== 32'h77 || bus.iss_ready_o !== 1'b0) begin
            errors++;
            $display("FAIL pre_reset got busy=%b d=%h ready=%b want 1 77 0",
                     bus.rs_busy_o[0], bus.rs_d_o[0], bus.iss_ready_o);
        end
        rst_i = 1'b1;
        bus.wb_we_i[1]  = 1'b1;
        bus.wb_a_i[1]   = 5'd9;
        bus.wb_d_i[1]   = 32'h33;
        bus.iss_valid_i = 1'b1;
        bus.iss_a_i     = 5'd10;
        #1;
        checks++;
        if (bus.rs_busy_o !== 2'b00 || bus.iss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL during_reset got busy=%b ready=%b want 00 1", bus.rs_busy_o, bus.iss_ready_o);
        end
        step();
        rst_i = 1'b0;
        idle();
        #1;
        checks++;
        if (bus.rs_d_o[0] !== 32'h0 || bus.rs_busy_o !== 2'b00 || bus_nb.rs_busy_o !== 2'b00) begin
            errors++;
            $display("FAIL post_reset_x8 got d=%h busy=%b/%b want 0 00/00",
                     bus.rs_d_o[0], bus.rs_busy_o, bus_nb.rs_busy_o);
        end
        bus.rs_a_i[0] = 5'd9;
        bus.rs_a_i[1] = 5'd10;
        bus.iss_a_i   = 5'd10;
        #1;
        checks++;
        if (bus.rs_d_o[0] !== 32'h0 || bus.rs_busy_o[1] !== 1'b0 || bus.iss_ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ignores got d9=%h busy10=%b ready=%b want 0 0 1",
                     bus.rs_d_o[0], bus.rs_busy_o[1], bus.iss_ready_o);
        end
    endtask

    initial begin
        test_reset();
        test_bypass();
        test_wr_priority();
        test_issue();
        test_issue_wb_same();
        test_x0();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/register_file_mp.md
REGISTER_FILE_MP -- requirements
Module: register_file_mp

Interface
REQ-001 Parameter NUM_RD, default 2, number of read ports (1..4).
REQ-002 Parameter NUM_WR, default 2, number of writeback ports (1..2).
REQ-003 Parameter BYPASS, default 1, 1 = same-cycle writeback data forwarded to read ports.
REQ-004 clk_i  input  1  single clock; all state updates on posedge.
REQ-005 rst_i  input  1  synchronous, active-high reset.
REQ-006 rs_a_i  input  NUM_RD x reg_e  read addresses.
REQ-007 rs_d_o  output  NUM_RD x word_st  read data.
REQ-008 rs_busy_o  output  NUM_RD x 1  addressed register has a pending write.
REQ-009 wb_we_i  input  NUM_WR x 1  writeback enable.
REQ-010 wb_a_i  input  NUM_WR x reg_e  writeback address.
REQ-011 wb_d_i  input  NUM_WR x word_st  writeback data.
REQ-012 iss_valid_i  input  1  issue request: marks iss_a_i pending.
REQ-013 iss_a_i  input  reg_e  destination register of issued instruction.
REQ-014 iss_ready_o  output  1  issue may be accepted this cycle.

Function
REQ-015 Storage: 32 x XLEN registers plus a 32-bit pending (scoreboard) vector.
REQ-016 Reads combinational: rs_d_o[i] = regfile[rs_a_i[i]], zero latency.
REQ-017 Address x0 reads 0, is never written, and its pending bit is always 0.
REQ-018 Write: on posedge with wb_we_i[j]=1 and wb_a_i[j]!=0, regfile[wb_a_i[j]] <= wb_d_i[j].
REQ-019 Two write ports same address same cycle: port NUM_WR-1 wins (higher index priority).
REQ-020 BYPASS=1: if any enabled wb port matches rs_a_i[i] (non-zero), rs_d_o[i] returns that wb_d_i (same priority as REQ-019), and rs_busy_o[i]=0 that cycle.
REQ-021 BYPASS=0: rs_d_o shows stored value; new value visible the cycle after write.
REQ-022 rs_busy_o[i] = pending[rs_a_i[i]], except as REQ-020.
REQ-023 iss_ready_o = !pending[iss_a_i] (WAW stall); 1 when iss_a_i=0.
REQ-024 Issue accepted when iss_valid_i && iss_ready_o; sets pending[iss_a_i] next cycle (not for x0).
REQ-025 Enabled writeback to register k clears pending[k] next cycle.
REQ-026 Simultaneous accepted issue and writeback to same k: pending[k] ends 1 (set wins); data still written.
REQ-027 Writeback to a non-pending register is legal: data written, pending unchanged (stays 0).
REQ-028 Issue with iss_valid_i=1, iss_ready_o=0: no state change; requester holds request.

Reset
REQ-029 rst_i=1 at posedge: all registers 0, pending vector 0; writes and issues that cycle ignored.
REQ-030 During/after reset: rs_d_o reflect stored values (0 once reset taken), rs_busy_o=0, iss_ready_o=1.
REQ-031 Reset mid-operation discards all pending marks; no initial-file load is used.

Structure
REQ-032 XLEN, word_st, reg_e, NREGS=32 come from definitions_pkg; no new package types required.
REQ-033 One sub-module natural: regfile_scoreboard (pending vector, issue/clear, ready/busy lookup).
REQ-034 Bypass/priority muxing SHALL be generate-loop code in the top, sized by parameters.

Verification
REQ-035 Reset then read x1..x31 on all ports -> 0, rs_busy_o=0, iss_ready_o=1.
REQ-036 wb0 x5=0xDEADBEEF, read x5 same cycle -> BYPASS=1: 0xDEADBEEF; BYPASS=0: old value, 0xDEADBEEF next cycle.
REQ-037 Same cycle wb0 x7=0x11, wb1 x7=0x22 -> x7 reads 0x22 afterwards.
REQ-038 Issue x3 -> next cycle rs_busy(x3)=1, iss_ready_o=0 for x3; wb x3=0x5 -> busy cleared next cycle, reads 0x5.
REQ-039 Issue x4 and wb x4=0x9 same cycle with x4 not pending -> x4=0x9, pending(x4)=1.
REQ-040 Write x0=0xFFFF, issue x0 -> reads 0, never busy; rst_i with x8 pending -> pending cleared, x8=0.
